// File: rtl/cceip_rbus_pkg.sv
// Shared types and defaults for the register-bus write arbiter and its helpers.
package cceip_rbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } rbus_arb_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned RBUS_ADDR_W = 20;
    localparam int unsigned RBUS_DATA_W = 32;

endpackage

// File: rtl/cceip_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, with wrap.
module cceip_rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int unsigned cand;

    always_comb begin
        idx  = last;
        any  = 1'b0;
        cand = 0;
        // Offset NUM_REQ wraps back to 'last' itself, so it has lowest priority.
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cceip_rbus_wr_arbiter.sv
// Round-robin sharing of one AXI4-Lite write port among NUM_REQ register-write requesters.
module cceip_rbus_wr_arbiter
    import cceip_rbus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = RBUS_ADDR_W,
    parameter int unsigned DATA_W  = RBUS_DATA_W,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam logic [9:0]  TO_LIM = 10'(TIMEOUT);

    rbus_arb_state_e state_q, state_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [9:0]         cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [9:0]         cnt_inc;
    logic               aw_pending;
    logic               w_pending;

    cceip_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req  (req_valid),
        .last (last_gnt_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_gnt_d = last_gnt_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        done_d     = '0;
        err_d      = '0;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        cnt_inc    = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
        aw_pending = awvalid_q && !m_axi_awready;
        w_pending  = wvalid_q && !m_axi_wready;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_idx_d = pick_idx;
                    awaddr_d  = req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
                    wdata_d   = req_wdata[int'(pick_idx) * DATA_W +: DATA_W];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (!aw_pending && !w_pending) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    bready_d           = 1'b0;
                    done_d[gnt_idx_q]  = 1'b1;
                    err_d[gnt_idx_q]   = (m_axi_bresp != RESP_OKAY);
                    last_gnt_d         = gnt_idx_q;
                    state_d            = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Flag only; the transaction cannot be abandoned once valids were issued.
                    if ((TIMEOUT != 0) && (cnt_inc >= TO_LIM)) timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            awaddr_q   <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_gnt_q <= last_gnt_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign req_done      = done_q;
    assign req_err       = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_cceip_rbus_wr_arbiter.sv
// Directed bench for the register-bus write arbiter; bridge side driven by hand per scenario.
module tb_cceip_rbus_wr_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 32;

    logic                      ap_clk;
    logic                      ap_rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;
    logic [ADDR_W-1:0]         m_axi_awaddr;
    logic                      m_axi_awvalid;
    logic                      m_axi_awready;
    logic [DATA_W-1:0]         m_axi_wdata;
    logic                      m_axi_wvalid;
    logic                      m_axi_wready;
    logic [1:0]                m_axi_bresp;
    logic                      m_axi_bvalid;
    logic                      m_axi_bready;
    logic                      busy;
    logic                      timeout_err;

    int vectors;
    int miscompares;

    logic [ADDR_W-1:0] addr_tab [NUM_REQ];
    logic [DATA_W-1:0] data_tab [NUM_REQ];

    cceip_rbus_wr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (16)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_done      (req_done),
        .req_err       (req_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid     = '0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bvalid  = 1'b0;
        ap_rst_n      = 1'b0;
        repeat (2) tick();
        ap_rst_n      = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (req_done !== 3'b000) begin miscompares++; $display("FAIL rst_done got %b want 000", req_done); end
        vectors++; if (req_err !== 3'b000) begin miscompares++; $display("FAIL rst_err got %b want 000", req_err); end
        vectors++; if (m_axi_awaddr !== 20'h0) begin miscompares++; $display("FAIL rst_awaddr got %h want 0", m_axi_awaddr); end
        vectors++; if (m_axi_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", m_axi_wdata); end
        vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b000) begin
            miscompares++; $display("FAIL rst_valids got %b want 000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        vectors++; if ({busy, timeout_err} !== 2'b00) begin miscompares++; $display("FAIL rst_busy_to got %b want 00", {busy, timeout_err}); end
    endtask

    task automatic test_single_write();
        apply_reset();
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        req_valid     = 3'b001;
        tick();
        vectors++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
            miscompares++; $display("FAIL single_valids got %b want 11", {m_axi_awvalid, m_axi_wvalid}); end
        vectors++; if (m_axi_awaddr !== 20'h00000) begin miscompares++; $display("FAIL single_awaddr got %h want 00000", m_axi_awaddr); end
        vectors++; if (m_axi_wdata !== 32'hce640000) begin miscompares++; $display("FAIL single_wdata got %h want ce640000", m_axi_wdata); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b want 1", busy); end
        tick();
        vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
            miscompares++; $display("FAIL single_resp got %b want 001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b00;
        tick();
        m_axi_bvalid = 1'b0;
        req_valid    = 3'b000;
        vectors++; if (req_done !== 3'b001) begin miscompares++; $display("FAIL single_done got %b want 001", req_done); end
        vectors++; if (req_err !== 3'b000) begin miscompares++; $display("FAIL single_err got %b want 000", req_err); end
        vectors++; if (m_axi_bready !== 1'b0) begin miscompares++; $display("FAIL single_bready_drop got %b want 0", m_axi_bready); end
        tick();
        vectors++; if ({req_done, busy} !== 4'b0000) begin
            miscompares++; $display("FAIL single_after got %b want 0000", {req_done, busy}); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_done;
        apply_reset();
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        req_valid     = 3'b111;
        for (int g = 0; g < 6; g++) begin
            int e;
            e = g % 3;
            exp_done = 3'b001 << e;
            tick();
            vectors++; if (m_axi_awaddr !== addr_tab[e] || m_axi_awvalid !== 1'b1) begin
                miscompares++; $display("FAIL contend_awaddr g%0d got %h/%b want %h/1", g, m_axi_awaddr, m_axi_awvalid, addr_tab[e]); end
            vectors++; if (m_axi_wdata !== data_tab[e]) begin
                miscompares++; $display("FAIL contend_wdata g%0d got %h want %h", g, m_axi_wdata, data_tab[e]); end
            tick();
            m_axi_bvalid = 1'b1;
            tick();
            m_axi_bvalid = 1'b0;
            vectors++; if ({req_done, req_err} !== {exp_done, 3'b000}) begin
                miscompares++; $display("FAIL contend_done g%0d got %b/%b want %b/000", g, req_done, req_err, exp_done); end
            tick();
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_skewed_handshake();
        apply_reset();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b1;
        req_valid     = 3'b001;
        tick();
        vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b110) begin
            miscompares++; $display("FAIL skew_c1 got %b want 110", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        for (int c = 2; c <= 3; c++) begin
            tick();
            vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b100 || m_axi_awaddr !== addr_tab[0]) begin
                miscompares++; $display("FAIL skew_c%0d got %b/%h want 100/%h", c,
                    {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, m_axi_awaddr, addr_tab[0]); end
        end
        m_axi_awready = 1'b1;
        tick();
        m_axi_awready = 1'b0;
        vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
            miscompares++; $display("FAIL skew_c4 got %b want 001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        req_valid    = 3'b000;
        vectors++; if (req_done !== 3'b001) begin miscompares++; $display("FAIL skew_done got %b want 001", req_done); end
        tick();
    endtask

    task automatic test_error_response();
        apply_reset();
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        req_valid     = 3'b010;
        tick();
        vectors++; if (m_axi_awaddr !== addr_tab[1]) begin
            miscompares++; $display("FAIL err_awaddr1 got %h want %h", m_axi_awaddr, addr_tab[1]); end
        tick();
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        tick();
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        req_valid    = 3'b100;
        vectors++; if ({req_done, req_err} !== 6'b010_010) begin
            miscompares++; $display("FAIL err_slverr got %b/%b want 010/010", req_done, req_err); end
        tick();
        tick();
        vectors++; if (m_axi_awaddr !== addr_tab[2]) begin
            miscompares++; $display("FAIL err_awaddr2 got %h want %h", m_axi_awaddr, addr_tab[2]); end
        tick();
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        req_valid    = 3'b000;
        vectors++; if ({req_done, req_err} !== 6'b100_000) begin
            miscompares++; $display("FAIL err_okay got %b/%b want 100/000", req_done, req_err); end
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        req_valid     = 3'b001;
        tick();
        tick();
        // k counts cycles spent in RESP; the flag is registered at the end of RESP cycle 16.
        for (int k = 1; k <= 40; k++) begin
            vectors++; if (timeout_err !== (k >= 17) || m_axi_bready !== 1'b1 || req_done !== 3'b000) begin
                miscompares++; $display("FAIL timeout_k%0d got to=%b br=%b done=%b want to=%b br=1 done=000", k,
                    timeout_err, m_axi_bready, req_done, (k >= 17)); end
            if (k < 40) tick();
        end
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        req_valid    = 3'b000;
        vectors++; if ({req_done, timeout_err} !== 4'b0011) begin
            miscompares++; $display("FAIL timeout_done got %b/%b want 001/1", req_done, timeout_err); end
        repeat (3) tick();
        vectors++; if ({busy, timeout_err} !== 2'b01) begin
            miscompares++; $display("FAIL timeout_sticky got %b want 01", {busy, timeout_err}); end
        ap_rst_n = 1'b0;
        #1;
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL timeout_clear got %b want 0", timeout_err); end
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_xfer();
        apply_reset();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        req_valid     = 3'b010;
        tick();
        vectors++; if (m_axi_awvalid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got %b want 1", m_axi_awvalid); end
        #2;
        ap_rst_n = 1'b0;
        #1;
        vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy} !== 4'b0000 || m_axi_awaddr !== 20'h0) begin
            miscompares++; $display("FAIL midrst_async got %b/%h want 0000/00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy}, m_axi_awaddr); end
        req_valid     = 3'b111;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        tick();
        ap_rst_n = 1'b1;
        tick();
        vectors++; if (m_axi_awaddr !== addr_tab[0] || m_axi_awvalid !== 1'b1) begin
            miscompares++; $display("FAIL midrst_first got %h/%b want %h/1", m_axi_awaddr, m_axi_awvalid, addr_tab[0]); end
        tick();
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        req_valid    = 3'b000;
        vectors++; if (req_done !== 3'b001) begin miscompares++; $display("FAIL midrst_done got %b want 001", req_done); end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        addr_tab[0] = 20'h00000;  data_tab[0] = 32'hce640000;
        addr_tab[1] = 20'h01234;  data_tab[1] = 32'h11112222;
        addr_tab[2] = 20'h0abcd;  data_tab[2] = 32'h33334444;
        req_addr    = {addr_tab[2], addr_tab[1], addr_tab[0]};
        req_wdata   = {data_tab[2], data_tab[1], data_tab[0]};
        ap_rst_n    = 1'b1;
        #2;

        test_reset();
        test_single_write();
        test_contention();
        test_skewed_handshake();
        test_error_response();
        test_timeout();
        test_reset_mid_xfer();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
